// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-8 serial demultiplexer.
package demux_pkg;

  localparam int unsigned DEMUX_WIDTH = 8;
  localparam int unsigned DEMUX_SEL_W = 3;

  typedef logic [DEMUX_SEL_W-1:0] demux_sel_t;

endpackage

// File: rtl/demux8_lane_ctr.sv
// Lane select / phase counter for demux8_deser: wraps after the last phase, flushes on clr.
// With DEMUX8_PARITY_EN the top passes LAST=WIDTH so one extra parity phase exists.
module demux8_lane_ctr
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH,
  parameter int unsigned SEL_W = $clog2(WIDTH),
  parameter int unsigned LAST  = WIDTH - 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_take,
  output logic [SEL_W-1:0] o_s,
  output logic             o_par_ph,
  output logic             o_last,
  output logic             o_done
);

  localparam logic [SEL_W:0]   LastPh = (SEL_W + 1)'(LAST);
  localparam logic [SEL_W-1:0] SelMax = SEL_W'(WIDTH - 1);
  localparam logic [SEL_W:0]   PhOne  = (SEL_W + 1)'(1);

  logic [SEL_W:0] r_phase;
  logic [SEL_W:0] w_phase_d;

  assign o_last   = (r_phase == LastPh);
  assign o_done   = i_take & o_last;
  // Phase WIDTH (MSB set) only exists in the parity build; s saturates there.
  assign o_par_ph = r_phase[SEL_W];
  assign o_s      = r_phase[SEL_W] ? SelMax : r_phase[SEL_W-1:0];

  always_comb begin
    w_phase_d = r_phase;
    if (i_clr) begin
      w_phase_d = '0;
    end else if (i_take) begin
      w_phase_d = o_last ? '0 : r_phase + PhOne;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_phase <= '0;
    end else begin
      r_phase <= w_phase_d;
    end
  end

endmodule

// File: rtl/demux8_deser.sv
// Serial-to-parallel 1-to-8 demultiplexer with valid/ready on both sides.
// Optional DEMUX8_PARITY_EN adds a trailing parity bit per word and the y_perr output.
module demux8_deser
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH,
  parameter int unsigned SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             clr,
  output logic [SEL_W-1:0] s,
  output logic [WIDTH-1:0] y,
  input  logic             y_ready,
`ifdef DEMUX8_PARITY_EN
  output logic             y_perr,
`endif
  output logic             y_valid
);

`ifdef DEMUX8_PARITY_EN
  localparam int unsigned LastPhase = WIDTH;
`else
  localparam int unsigned LastPhase = WIDTH - 1;
`endif

  logic             w_take;
  logic             w_done;
  logic             w_last;
  logic             w_par_ph;
  logic [SEL_W-1:0] w_s;

  logic [WIDTH-1:0] r_asm;
  logic [WIDTH-1:0] w_asm_d;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] w_y_d;
  logic             r_y_valid;
  logic             w_y_valid_d;
  logic             r_y_perr;
  logic             w_y_perr_d;

  // Stall only the completing bit; earlier bits of the next word may queue up in r_asm.
  assign din_ready = !(w_last && r_y_valid && !y_ready);
  assign w_take    = din_valid & din_ready & ~clr;

  demux8_lane_ctr #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W),
    .LAST  (LastPhase)
  ) u_lane_ctr (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_clr    (clr),
    .i_take   (w_take),
    .o_s      (w_s),
    .o_par_ph (w_par_ph),
    .o_last   (w_last),
    .o_done   (w_done)
  );

  always_comb begin
    w_asm_d     = r_asm;
    w_y_d       = r_y;
    w_y_valid_d = r_y_valid;
    w_y_perr_d  = r_y_perr;

    if (clr) begin
      w_asm_d = '0;
    end else if (w_take && !w_par_ph) begin
      w_asm_d[w_s] = din;
    end

    if (r_y_valid && y_ready) begin
      w_y_valid_d = 1'b0;
    end

    if (w_done) begin
      w_y_valid_d = 1'b1;
`ifdef DEMUX8_PARITY_EN
      w_y_d      = r_asm;
      w_y_perr_d = ^{r_asm, din};
`else
      w_y_d      = {din, r_asm[WIDTH-2:0]};
      w_y_perr_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_asm     <= '0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_y_perr  <= 1'b0;
    end else begin
      r_asm     <= w_asm_d;
      r_y       <= w_y_d;
      r_y_valid <= w_y_valid_d;
      r_y_perr  <= w_y_perr_d;
    end
  end

  assign s       = w_s;
  assign y       = r_y;
  assign y_valid = r_y_valid;
`ifdef DEMUX8_PARITY_EN
  assign y_perr  = r_y_perr;
`else
  logic w_unused_perr;
  assign w_unused_perr = r_y_perr;
`endif

endmodule

// File: tb/tb_demux8_deser.sv
// Scoreboard bench for demux8_deser: bit-list reference model feeds an expected-word queue,
// a negedge monitor pops and compares on every y_valid & y_ready transfer.
module tb_demux8_deser;

  localparam int W = 8;
`ifdef DEMUX8_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         din = 1'b0;
  logic         din_valid = 1'b0;
  logic         clr = 1'b0;
  logic         y_ready = 1'b0;
  logic         din_ready;
  logic [2:0]   s;
  logic [W-1:0] y;
  logic         y_valid;
`ifdef DEMUX8_PARITY_EN
  logic         y_perr;
`endif

  int total = 0;
  int bad = 0;

  // Reference model state: bits of the partial word, output occupancy, expected words.
  int           m_cnt = 0;
  bit           m_full = 0;
  logic [W-1:0] m_word = '0;
  logic [W:0]   sb_q[$];

  always #5 clk = ~clk;

  demux8_deser dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .clr       (clr),
    .s         (s),
    .y         (y),
    .y_ready   (y_ready),
`ifdef DEMUX8_PARITY_EN
    .y_perr    (y_perr),
`endif
    .y_valid   (y_valid)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  // One clock of stimulus; compares handshake/state against the model, then advances the model.
  task automatic step(input bit v, input bit d, input bit yr, input bit c, output bit acc);
    bit exp_rdy;
    int exp_s;
    @(posedge clk);
    #1;
    din_valid = v;
    din       = d;
    y_ready   = yr;
    clr       = c;
    @(negedge clk);
    exp_rdy = !(m_cnt == NB - 1 && m_full && !yr);
    exp_s   = (m_cnt > W - 1) ? W - 1 : m_cnt;
    chk("din_ready", int'(din_ready), int'(exp_rdy));
    chk("s", int'(s), exp_s);
    chk("y_valid", int'(y_valid), int'(m_full));
    acc = v && exp_rdy && !c;
    if (m_full && yr) m_full = 0;
    if (c) begin
      m_cnt  = 0;
      m_word = '0;
    end else if (acc) begin
      if (m_cnt < W) m_word[m_cnt] = d;
      m_cnt++;
      if (m_cnt == NB) begin
`ifdef DEMUX8_PARITY_EN
        sb_q.push_back({^{m_word, d}, m_word});
`else
        sb_q.push_back({1'b0, m_word});
`endif
        m_full = 1;
        m_cnt  = 0;
        m_word = '0;
      end
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit par, input bit yr);
    bit acc;
    bit b;
    int tries;
    for (int i = 0; i < NB; i++) begin
      b = (i < W) ? w[i] : par;
      tries = 0;
      acc = 0;
      while (!acc && tries < 20) begin
        step(1, b, yr, 0, acc);
        tries++;
      end
      if (!acc) chk("send_timeout", 0, 1);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    din_valid = 1'b0;
    clr       = 1'b0;
    y_ready   = 1'b0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    m_cnt  = 0;
    m_full = 0;
    m_word = '0;
    sb_q.delete();
    @(negedge clk);
    chk("rst_s", int'(s), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_y_valid", int'(y_valid), 0);
    chk("rst_din_ready", int'(din_ready), 1);
  endtask

  // Monitor: every output transfer must match the oldest expected word.
  always @(negedge clk) begin
    logic [W:0] e;
    if (rst_n && y_valid && y_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL y_pop: unexpected word 0x%0h, no word expected", y);
      end else begin
        e = sb_q.pop_front();
        chk("y_pop", int'(y), int'(e[W-1:0]));
`ifdef DEMUX8_PARITY_EN
        chk("y_perr_pop", int'(y_perr), int'(e[W]));
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         acc;
    bit         lastb;
    logic [W-1:0] c3;
    c3 = 8'h3C;

    do_reset();

    // Word assembly with lane order 0..7
    send_word(8'hAF, 0, 1);
    step(0, 0, 1, 0, acc);
    chk("word1_y", int'(y), 'hAF);
    step(0, 0, 1, 0, acc);

    // Backpressure: hold AF, queue all but the completing bit of 3C
    send_word(8'hAF, 0, 0);
    for (int i = 0; i < NB - 1; i++) step(1, c3[i], 0, 0, acc);
    lastb = (NB > W) ? 1'b0 : c3[W-1];
    step(1, lastb, 0, 0, acc);
    chk("bp_stall", int'(din_ready), 0);
    chk("bp_hold", int'(y), 'hAF);
    step(1, lastb, 1, 0, acc);
    step(0, 0, 0, 0, acc);
    chk("bp_next", int'(y), 'h3C);
    step(0, 0, 1, 0, acc);

    // Back-to-back words at full rate
    send_word(8'h01, 0, 1);
    send_word(8'h80, 1, 1);
    send_word(8'hFF, 0, 1);
    step(0, 0, 1, 0, acc);
    step(0, 0, 1, 0, acc);

    // Flush mid-word; the bit presented with clr is dropped
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, acc);
    step(1, 1, 1, 1, acc);
    step(0, 0, 1, 0, acc);
    chk("flush_s", int'(s), 0);
    send_word(8'h55, 0, 1);
    step(0, 0, 0, 0, acc);
    chk("flush_y", int'(y), 'h55);
    step(0, 0, 1, 0, acc);

    // Reset mid-word
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0, acc);
    do_reset();
    send_word(8'h96, 0, 1);
    step(0, 0, 0, 0, acc);
    chk("post_rst_y", int'(y), 'h96);
    step(0, 0, 1, 0, acc);

`ifdef DEMUX8_PARITY_EN
    send_word(8'hAF, 0, 1);
    step(0, 0, 0, 0, acc);
    chk("perr0", int'(y_perr), 0);
    step(0, 0, 1, 0, acc);
    send_word(8'hAF, 1, 1);
    step(0, 0, 0, 0, acc);
    chk("perr1", int'(y_perr), 1);
    step(0, 0, 1, 0, acc);
`endif

    // Randomized traffic with backpressure and occasional flushes
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(3) != 0), 1'($urandom), ($urandom_range(2) != 0),
           ($urandom_range(39) == 0), acc);
    end
    for (int n = 0; n < 4; n++) step(0, 0, 1, 0, acc);
    chk("sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux8_deser.md
Name: demux8_deser

Overview:
- Sequential 1-to-8 demultiplexer. It is the receive-side counterpart of the 8:1 select mux.
- Accepts a serial bit stream one bit per handshake and steers each bit to output lane 0..7 using an internal select counter.
- Presents the assembled 8-bit word with a valid/ready handshake.
- Sits after a mux-based parallel-to-serial stage, restoring the original din vector.

Parameters:
- WIDTH, 8, number of output lanes; power of two, minimum 2.
- SEL_W, $clog2(WIDTH), width of the lane select counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- din  input  1  serial data bit
- din_valid  input  1  din is valid this cycle
- din_ready  output  1  block can accept din this cycle
- clr  input  1  synchronous flush of the partial word
- s  output  SEL_W  current lane select, i.e. the lane the next accepted bit goes to
- y  output  WIDTH  assembled word
- y_valid  output  1  y holds a complete word
- y_ready  input  1  consumer takes y this cycle

Behaviour:
- Clock/reset: one clock (clk); reset synchronous, active-low (rst_n), sampled on rising edge of clk.
- Reset values: s=0, internal assembly register asm=0, y=0, y_valid=0. din_ready reads 1 in the first cycle after reset.
- Accept: acc = din_valid & din_ready. On acc, asm[s] <= din and s <= s+1. s wraps modulo WIDTH.
- Lane order: the first accepted bit goes to y[0] and the last to y[WIDTH-1], matching mux select order 0..7.
- Completion: acc while s==WIDTH-1 loads y <= {din, asm[WIDTH-2:0]}, sets y_valid=1 on the next edge, and sets s=0.
  - Latency: y_valid rises 1 cycle after the last bit is accepted.
- Output handshake: y_valid & y_ready clears y_valid next edge. y is held stable while y_valid=1 and y_ready=0.
- Backpressure: din_ready = !(s==WIDTH-1 && y_valid && !y_ready). Combinational, no combinational path from din_valid.
  - Bits 0..WIDTH-2 of the next word may be accepted while the previous word is still waiting.
- Simultaneous completion and output pop: y_ready=1 with y_valid=1 and a completing acc gives new y loaded and y_valid stays 1. Sustained throughput is 1 bit/cycle.
- clr: s <= 0 and asm <= 0; y and y_valid are unaffected. If clr and acc occur in the same cycle, clr wins and the bit is dropped.
- rst_n mid-word: partial word discarded, all state returns to reset values.
- din_valid=0: no state change.

Optional Feature:
- Macro: DEMUX8_PARITY_EN.
- Enabled:
  - Adds output y_perr (1 bit, reset 0).
  - After lane WIDTH-1, one extra parity bit is accepted; the internal phase counter runs 0..WIDTH.
  - Completion occurs on the parity bit instead. y_perr = ^{word, parity} (even parity expected), valid with y_valid, and held with y.
  - The din_ready stall condition moves to phase==WIDTH.
  - s output saturates at WIDTH-1 during the parity phase.
- Disabled: no y_perr port; behaviour as above.

Decomposition:
- Shared package demux_pkg: DEMUX_WIDTH=8, DEMUX_SEL_W=3, typedef demux_sel_t = logic[2:0].
- One sub-module: demux8_lane_ctr, the select/phase counter with wrap, clr, and completion flag. Steering, assembly, and the output register stay in the top module.

Test Plan:
- Word assembly: din_valid=1, y_ready=1, bits 1,1,1,1,0,1,0,1 on consecutive cycles -> s counts 0..7 then wraps to 0; y=8'b10101111, y_valid=1 exactly one cycle after the 8th bit.
- Backpressure: y_ready=0, word 8'hAF done, send 7 bits of 8'h3C -> all accepted; 8th bit sees din_ready=0 and y holds 8'hAF. Raise y_ready -> 8'hAF popped, 8'h3C presented the following cycle.
- Back-to-back words: 3 words 8'h01, 8'h80, 8'hFF, y_ready=1, din_valid=1 for 24 cycles -> no stall; y_valid pulses on cycles 9, 17, 25.
- Flush: 4 bits accepted, clr=1 with din_valid=1 -> bit dropped, s=0. Next 8 bits of 8'h55 -> y=8'h55.
- Reset mid-word: 5 bits accepted, rst_n=0 for 1 cycle -> s=0, y=0, y_valid=0. A following full word assembles correctly.
- DEMUX8_PARITY_EN: word 8'hAF plus parity 0 -> y_perr=0; same word plus parity 1 -> y_perr=1.
